// File: rtl/io_fsm_multi.sv
// Host-bus front-end for NUM_CH decompressors: lane split, round-robin word steering,
// per-channel object counting and the IDLE/DECOMP/CALC/DONE command sequencer.
// The host strobe and command qualifier are named intr / proc_sel because int and process are reserved words.
module io_fsm_multi #(
  parameter int NUM_CH  = 4,
  parameter int LANE_W  = 8,
  parameter int OBJ_CNT = 2,
  parameter int CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     intr,
  input  logic                     proc_sel,
  input  logic                     data_valid,
  input  logic [NUM_CH*LANE_W-1:0] data,
  input  logic                     eob,
  input  logic                     ready,
  output logic [NUM_CH*LANE_W-1:0] lane_data,
  output logic [NUM_CH-1:0]        lane_valid,
  output logic [NUM_CH-1:0]        start,
  output logic [NUM_CH-1:0]        finish,
  output logic                     next,
  output logic                     all_done,
  output logic                     done,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DECOMP = 2'b01,
    S_CALC   = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] OBJ_LIM  = CNT_W'(OBJ_CNT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_inc;
  logic [NUM_CH-1:0] finish_d, lane_valid_d, start_d;
  logic              next_d, done_d;

  // Lane i is simply the i-th LANE_W slice of the bus word.
  assign lane_data = data;
  assign all_done  = &finish;
  assign state     = state_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    finish_d     = finish;
    lane_valid_d = '0;
    start_d      = '0;
    next_d       = 1'b0;
    done_d       = 1'b0;
    cnt_inc      = cnt_q[ptr_q] + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (intr && !proc_sel) begin
          state_d  = S_DECOMP;
          ptr_d    = '0;
          finish_d = '0;
          start_d  = '1;
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
        end
      end

      S_DECOMP: begin
        if (data_valid) begin
          next_d = 1'b1;
          // Words aimed at a finished channel are consumed but never delivered or counted.
          if (!finish[ptr_q]) begin
            lane_valid_d[ptr_q] = 1'b1;
            if (eob) begin
              cnt_d[ptr_q] = cnt_inc;
              if (cnt_inc == OBJ_LIM) finish_d[ptr_q] = 1'b1;
            end
          end
          if (ptr_q == LAST_PTR) begin
            ptr_d   = '0;
            start_d = ~finish_d;
          end else begin
            ptr_d = ptr_q + CNT_W'(1);
          end
        end
        if (intr && proc_sel) state_d = S_CALC;
      end

      S_CALC: begin
        if (ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      finish     <= '0;
      lane_valid <= '0;
      start      <= '0;
      next       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      finish     <= finish_d;
      lane_valid <= lane_valid_d;
      start      <= start_d;
      next       <= next_d;
      done       <= done_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
